// File: rtl/trap_commit_pkg.sv
// Shared constants and types for the commit stage: CSR addresses and
// privilege encodings (common), commit bundle and trap FSM state (pipes).

package common;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [1:0]  PRIV_U      = 2'd0;
    localparam logic [1:0]  PRIV_M      = 2'd3;

    // mstatus field positions
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;
endpackage

package pipes;
    localparam int unsigned DATA_W = 64;

    // One memory-stage instruction as presented to commit
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic              regwrite;
        logic [4:0]        dst;
        logic [DATA_W-1:0] result;
        logic              csrwrite;
        logic [11:0]       csraddr;
        logic [DATA_W-1:0] csrdata;
        logic              excep;
        logic [DATA_W-1:0] cause;
        logic [DATA_W-1:0] tval;
        logic              mret;
    } commit_data_t;

    typedef enum logic [1:0] {
        IDLE,
        T_CAUSE,
        T_TVAL,
        T_STATUS
    } trap_state_t;
endpackage

// File: rtl/trap_commit_if.sv
// Commit bus: memory-stage instruction in, GPR/CSR write side and fetch
// redirect out. master = upstream/environment, slave = trap_commit.

interface trap_commit_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic            in_regwrite;
    logic [4:0]      in_dst;
    logic [XLEN-1:0] in_result;
    logic            in_csrwrite;
    logic [11:0]     in_csraddr;
    logic [XLEN-1:0] in_csrdata;
    logic            in_excep;
    logic [XLEN-1:0] in_cause;
    logic [XLEN-1:0] in_tval;
    logic            in_mret;
    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic            wen;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;
    logic            csr_wen;
    logic [11:0]     csr_wa;
    logic [XLEN-1:0] csr_wd;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      priv;
    logic [63:0]     instret;

    modport master (
        output in_valid, in_pc, in_regwrite, in_dst, in_result,
               in_csrwrite, in_csraddr, in_csrdata, in_excep, in_cause,
               in_tval, in_mret, mstatus_q, mtvec_q, mepc_q,
        input  in_ready, wen, wa, wd, csr_wen, csr_wa, csr_wd,
               redirect_valid, redirect_pc, priv, instret
    );

    modport slave (
        input  in_valid, in_pc, in_regwrite, in_dst, in_result,
               in_csrwrite, in_csraddr, in_csrdata, in_excep, in_cause,
               in_tval, in_mret, mstatus_q, mtvec_q, mepc_q,
        output in_ready, wen, wa, wd, csr_wen, csr_wa, csr_wd,
               redirect_valid, redirect_pc, priv, instret
    );
endinterface

// File: rtl/trap_commit_mstatus_xfer.sv
// mstatus transforms for trap entry and mret, plus the privilege mret returns to.

module mstatus_xfer
    import common::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] trap_src,
    input  logic [1:0]      trap_priv,
    input  logic [XLEN-1:0] mret_src,
    output logic [XLEN-1:0] trap_val,
    output logic [XLEN-1:0] mret_val,
    output logic [1:0]      mret_priv
);

    // Trap: stash MIE in MPIE, mask interrupts, record the trapping privilege.
    // mret: restore MIE from MPIE, re-arm MPIE, drop MPP back to U.
    always_comb begin
        trap_val                                = trap_src;
        trap_val[MSTATUS_MPIE]                  = trap_src[MSTATUS_MIE];
        trap_val[MSTATUS_MIE]                   = 1'b0;
        trap_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = trap_priv;

        mret_val                                = mret_src;
        mret_val[MSTATUS_MIE]                   = mret_src[MSTATUS_MPIE];
        mret_val[MSTATUS_MPIE]                  = 1'b1;
        mret_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    end

    assign mret_priv = mret_src[MSTATUS_MPP_HI:MSTATUS_MPP_LO];

endmodule

// File: rtl/trap_commit.sv
// Writeback/commit stage: retires GPR/CSR writes, counts retired
// instructions, sequences trap entry over the single CSR write port,
// executes mret and owns the current privilege mode.

module trap_commit
    import common::*;
    import pipes::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          MTVEC_VEC_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    trap_commit_if.slave  bus
);

    trap_state_t     state_q, state_d;
    commit_data_t    cur;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] mstatus_snap_q;
    logic [1:0]      priv_snap_q;
    logic [1:0]      priv_q;
    logic [63:0]     instret_q;

    logic [XLEN-1:0] trap_mstatus;
    logic [XLEN-1:0] mret_mstatus;
    logic [1:0]      mret_priv;
    logic [XLEN-1:0] trap_base;
    logic            trap_vectored;
    logic [XLEN-1:0] trap_target;
    logic            accept;

    // Bundle the incoming instruction fields
    always_comb begin
        cur.valid    = bus.in_valid;
        cur.pc       = DATA_W'(bus.in_pc);
        cur.regwrite = bus.in_regwrite;
        cur.dst      = bus.in_dst;
        cur.result   = DATA_W'(bus.in_result);
        cur.csrwrite = bus.in_csrwrite;
        cur.csraddr  = bus.in_csraddr;
        cur.csrdata  = DATA_W'(bus.in_csrdata);
        cur.excep    = bus.in_excep;
        cur.cause    = DATA_W'(bus.in_cause);
        cur.tval     = DATA_W'(bus.in_tval);
        cur.mret     = bus.in_mret;
    end

    assign accept = cur.valid && (state_q == IDLE);

    mstatus_xfer #(
        .XLEN (XLEN)
    ) u_mstatus_xfer (
        .trap_src  (mstatus_snap_q),
        .trap_priv (priv_snap_q),
        .mret_src  (bus.mstatus_q),
        .trap_val  (trap_mstatus),
        .mret_val  (mret_mstatus),
        .mret_priv (mret_priv)
    );

    // Trap vector: direct base, or base + 4*cause for vectored interrupts
    always_comb begin
        trap_base     = {bus.mtvec_q[XLEN-1:2], 2'b00};
        trap_vectored = MTVEC_VEC_EN && (bus.mtvec_q[1:0] == 2'b01) && cause_q[XLEN-1];
        trap_target   = trap_vectored ? trap_base + XLEN'({cause_q[5:0], 2'b00}) : trap_base;
    end

    // Next state and commit outputs; everything held at zero while reset is asserted
    always_comb begin
        state_d            = state_q;
        bus.in_ready       = 1'b0;
        bus.wen            = 1'b0;
        bus.wa             = '0;
        bus.wd             = '0;
        bus.csr_wen        = 1'b0;
        bus.csr_wa         = '0;
        bus.csr_wd         = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    bus.in_ready = 1'b1;
                    if (cur.valid) begin
                        if (cur.excep) begin
                            bus.csr_wen = 1'b1;
                            bus.csr_wa  = CSR_MEPC;
                            bus.csr_wd  = XLEN'(cur.pc);
                            state_d     = T_CAUSE;
                        end else if (cur.mret) begin
                            bus.csr_wen        = 1'b1;
                            bus.csr_wa         = CSR_MSTATUS;
                            bus.csr_wd         = mret_mstatus;
                            bus.redirect_valid = 1'b1;
                            bus.redirect_pc    = bus.mepc_q;
                        end else begin
                            bus.wen     = cur.regwrite && (cur.dst != 5'd0);
                            bus.wa      = cur.dst;
                            bus.wd      = XLEN'(cur.result);
                            bus.csr_wen = cur.csrwrite;
                            bus.csr_wa  = cur.csraddr;
                            bus.csr_wd  = XLEN'(cur.csrdata);
                        end
                    end
                end
                T_CAUSE: begin
                    bus.csr_wen = 1'b1;
                    bus.csr_wa  = CSR_MCAUSE;
                    bus.csr_wd  = cause_q;
                    state_d     = T_TVAL;
                end
                T_TVAL: begin
                    bus.csr_wen = 1'b1;
                    bus.csr_wa  = CSR_MTVAL;
                    bus.csr_wd  = tval_q;
                    state_d     = T_STATUS;
                end
                T_STATUS: begin
                    bus.csr_wen        = 1'b1;
                    bus.csr_wa         = CSR_MSTATUS;
                    bus.csr_wd         = trap_mstatus;
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = trap_target;
                    state_d            = IDLE;
                end
            endcase
        end
    end

    // State, trap context latch, privilege and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cause_q        <= '0;
            tval_q         <= '0;
            mstatus_snap_q <= '0;
            priv_snap_q    <= PRIV_M;
            priv_q         <= PRIV_M;
            instret_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (cur.excep) begin
                    cause_q        <= XLEN'(cur.cause);
                    tval_q         <= XLEN'(cur.tval);
                    mstatus_snap_q <= bus.mstatus_q;
                    priv_snap_q    <= priv_q;
                end else if (cur.mret) begin
                    priv_q    <= mret_priv;
                    instret_q <= instret_q + 64'd1;
                end else begin
                    instret_q <= instret_q + 64'd1;
                end
            end
            if (state_q == T_STATUS) begin
                priv_q <= PRIV_M;
            end
        end
    end

    assign bus.priv    = priv_q;
    assign bus.instret = instret_q;

endmodule

// File: tb/tb_trap_commit.sv
// Self-checking bench for trap_commit: directed scenarios followed by a
// randomized instruction stream, checked cycle by cycle against a
// behavioural model of the commit rules.

module tb_trap_commit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // Model state
    logic [1:0]  m_priv;
    logic [63:0] m_instret;

    trap_commit_if #(.XLEN(64)) bus ();

    trap_commit #(
        .XLEN         (64),
        .MTVEC_VEC_EN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Expected mstatus after trap entry from privilege p
    function automatic logic [63:0] exp_trap_mstatus(input logic [63:0] m, input logic [1:0] p);
        logic [63:0] r;
        r = m & ~64'h1888;
        if (m[3]) r = r | 64'h80;
        r = r | ({62'd0, p} << 11);
        return r;
    endfunction

    // Expected mstatus after mret
    function automatic logic [63:0] exp_mret_mstatus(input logic [63:0] m);
        logic [63:0] r;
        r = (m & ~64'h1888) | 64'h80;
        if (m[7]) r = r | 64'h8;
        return r;
    endfunction

    function automatic logic [63:0] exp_target(input logic [63:0] mtvec, input logic [63:0] cause);
        logic [63:0] base;
        base = mtvec & ~64'h3;
        if ((mtvec % 4) == 1 && cause[63]) return base + (cause % 64) * 4;
        return base;
    endfunction

    task automatic drive_junk_idle();
        bus.in_valid    = 1'b0;
        bus.in_regwrite = 1'b1;
        bus.in_dst      = 5'(1 + $urandom_range(0, 30));
        bus.in_result   = {$urandom, $urandom};
        bus.in_csrwrite = 1'b1;
        bus.in_csraddr  = 12'h7c0;
        bus.in_excep    = $urandom_range(0, 1) == 1;
        bus.in_mret     = $urandom_range(0, 1) == 1;
    endtask

    // One cycle with nothing valid: no writes, no redirect, state untouched
    task automatic idle_cycle();
        drive_junk_idle();
        #3;
        chk("idle_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("idle_wen", {63'd0, bus.wen}, 64'd0);
        chk("idle_csr_wen", {63'd0, bus.csr_wen}, 64'd0);
        chk("idle_redirect", {63'd0, bus.redirect_valid}, 64'd0);
        chk("idle_instret", bus.instret, m_instret);
        edge_step();
    endtask

    // Present one instruction (called at posedge+1) and check every cycle it occupies
    task automatic run_instr(
        input logic        rw, input logic [4:0] dst, input logic [63:0] res,
        input logic        cw, input logic [11:0] ca, input logic [63:0] cd,
        input logic        ex, input logic [63:0] cause, input logic [63:0] tval,
        input logic        mr, input logic [63:0] pc, input logic [63:0] mst,
        input logic [63:0] mtvec, input logic [63:0] mepc
    );
        logic [1:0] p0;
        bus.in_valid    = 1'b1;
        bus.in_regwrite = rw;
        bus.in_dst      = dst;
        bus.in_result   = res;
        bus.in_csrwrite = cw;
        bus.in_csraddr  = ca;
        bus.in_csrdata  = cd;
        bus.in_excep    = ex;
        bus.in_cause    = cause;
        bus.in_tval     = tval;
        bus.in_mret     = mr;
        bus.in_pc       = pc;
        bus.mstatus_q   = mst;
        bus.mtvec_q     = mtvec;
        bus.mepc_q      = mepc;
        p0 = m_priv;
        #3;
        chk("ready", {63'd0, bus.in_ready}, 64'd1);
        chk("priv", {62'd0, bus.priv}, {62'd0, m_priv});
        chk("instret", bus.instret, m_instret);
        if (ex) begin
            chk("trap_mepc_wen", {63'd0, bus.wen}, 64'd0);
            chk("trap_mepc_csr_wen", {63'd0, bus.csr_wen}, 64'd1);
            chk("trap_mepc_wa", {52'd0, bus.csr_wa}, 64'h341);
            chk("trap_mepc_wd", bus.csr_wd, pc);
            chk("trap_mepc_redir", {63'd0, bus.redirect_valid}, 64'd0);
            edge_step();
            // mstatus_q must not be re-read after acceptance
            bus.mstatus_q = ~mst;
            #3;
            chk("trap_cause_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("trap_cause_wen", {63'd0, bus.wen}, 64'd0);
            chk("trap_cause_csr_wen", {63'd0, bus.csr_wen}, 64'd1);
            chk("trap_cause_wa", {52'd0, bus.csr_wa}, 64'h342);
            chk("trap_cause_wd", bus.csr_wd, cause);
            chk("trap_cause_redir", {63'd0, bus.redirect_valid}, 64'd0);
            edge_step();
            #3;
            chk("trap_tval_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("trap_tval_wen", {63'd0, bus.wen}, 64'd0);
            chk("trap_tval_csr_wen", {63'd0, bus.csr_wen}, 64'd1);
            chk("trap_tval_wa", {52'd0, bus.csr_wa}, 64'h343);
            chk("trap_tval_wd", bus.csr_wd, tval);
            chk("trap_tval_redir", {63'd0, bus.redirect_valid}, 64'd0);
            edge_step();
            #3;
            chk("trap_stat_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("trap_stat_wen", {63'd0, bus.wen}, 64'd0);
            chk("trap_stat_csr_wen", {63'd0, bus.csr_wen}, 64'd1);
            chk("trap_stat_wa", {52'd0, bus.csr_wa}, 64'h300);
            chk("trap_stat_wd", bus.csr_wd, exp_trap_mstatus(mst, p0));
            chk("trap_stat_redir", {63'd0, bus.redirect_valid}, 64'd1);
            chk("trap_stat_target", bus.redirect_pc, exp_target(mtvec, cause));
            chk("trap_stat_priv", {62'd0, bus.priv}, {62'd0, p0});
            chk("trap_stat_instret", bus.instret, m_instret);
            edge_step();
            m_priv = 2'd3;
        end else if (mr) begin
            chk("mret_wen", {63'd0, bus.wen}, 64'd0);
            chk("mret_csr_wen", {63'd0, bus.csr_wen}, 64'd1);
            chk("mret_csr_wa", {52'd0, bus.csr_wa}, 64'h300);
            chk("mret_csr_wd", bus.csr_wd, exp_mret_mstatus(mst));
            chk("mret_redir", {63'd0, bus.redirect_valid}, 64'd1);
            chk("mret_target", bus.redirect_pc, mepc);
            edge_step();
            m_priv    = mst[12:11];
            m_instret = m_instret + 1;
        end else begin
            chk("norm_wen", {63'd0, bus.wen}, {63'd0, rw && dst != 0});
            if (rw && dst != 0) begin
                chk("norm_wa", {59'd0, bus.wa}, {59'd0, dst});
                chk("norm_wd", bus.wd, res);
            end
            chk("norm_csr_wen", {63'd0, bus.csr_wen}, {63'd0, cw});
            if (cw) begin
                chk("norm_csr_wa", {52'd0, bus.csr_wa}, {52'd0, ca});
                chk("norm_csr_wd", bus.csr_wd, cd);
            end
            chk("norm_redir", {63'd0, bus.redirect_valid}, 64'd0);
            edge_step();
            m_instret = m_instret + 1;
        end
        bus.in_valid = 1'b0;
        bus.in_excep = 1'b0;
        bus.in_mret  = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_priv    = 2'd3;
        m_instret = 64'd0;
        reset     = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_pc       = '0;
        bus.in_regwrite = 1'b0;
        bus.in_dst      = '0;
        bus.in_result   = '0;
        bus.in_csrwrite = 1'b0;
        bus.in_csraddr  = '0;
        bus.in_csrdata  = '0;
        bus.in_excep    = 1'b0;
        bus.in_cause    = '0;
        bus.in_tval     = '0;
        bus.in_mret     = 1'b0;
        bus.mstatus_q   = '0;
        bus.mtvec_q     = '0;
        bus.mepc_q      = '0;

        // Reset values
        edge_step();
        edge_step();
        #2;
        chk("rst_priv", {62'd0, bus.priv}, 64'd3);
        chk("rst_instret", bus.instret, 64'd0);
        chk("rst_wen", {63'd0, bus.wen}, 64'd0);
        chk("rst_csr_wen", {63'd0, bus.csr_wen}, 64'd0);
        chk("rst_redir", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst_csr_wd", bus.csr_wd, 64'd0);
        edge_step();
        reset = 1'b0;
        idle_cycle();

        // Normal writes: x5 = 0x10, then a write to x0 (suppressed)
        run_instr(1, 5'd5, 64'h10, 0, 12'h0, 64'h0, 0, 64'h0, 64'h0, 0, 64'h8000_0000, 64'h0, 64'h0, 64'h0);
        run_instr(1, 5'd0, 64'h33, 0, 12'h0, 64'h0, 0, 64'h0, 64'h0, 0, 64'h8000_0004, 64'h0, 64'h0, 64'h0);
        // Simultaneous GPR and CSR write
        run_instr(1, 5'd7, 64'h1234, 1, 12'h340, 64'hcafe, 0, 64'h0, 64'h0, 0, 64'h8000_0008, 64'h0, 64'h0, 64'h0);
        idle_cycle();

        // Exception, direct mode
        run_instr(0, 5'd0, 64'h0, 0, 12'h0, 64'h0, 1, 64'd2, 64'hdead, 0,
                  64'h8000_0010, 64'h8, 64'h8000_0100, 64'h0);
        // Vectored interrupt
        run_instr(0, 5'd0, 64'h0, 0, 12'h0, 64'h0, 1, 64'h8000_0000_0000_0007, 64'h0, 0,
                  64'h8000_0020, 64'h0, 64'h8000_0101, 64'h0);
        // mret back to U
        run_instr(0, 5'd0, 64'h0, 0, 12'h0, 64'h0, 0, 64'h0, 64'h0, 1,
                  64'h8000_0030, 64'h80, 64'h0, 64'h8000_0200);
        chk("mret_priv_after", {62'd0, bus.priv}, 64'd0);
        // Exception with GPR and CSR writes requested, taken from U
        run_instr(1, 5'd9, 64'h55, 1, 12'h7c0, 64'h66, 1, 64'd5, 64'h44, 0,
                  64'h8000_0040, 64'h0, 64'h8000_0100, 64'h0);
        // Exception and mret both set: trap path
        run_instr(0, 5'd0, 64'h0, 0, 12'h0, 64'h0, 1, 64'd11, 64'h0, 1,
                  64'h8000_0050, 64'h1888, 64'h8000_0300, 64'h8000_0400);
        idle_cycle();

        // Reset asserted in T_TVAL
        bus.in_valid  = 1'b1;
        bus.in_excep  = 1'b1;
        bus.in_mret   = 1'b0;
        bus.in_cause  = 64'd3;
        bus.in_tval   = 64'h77;
        bus.in_pc     = 64'h8000_0060;
        bus.mstatus_q = 64'h8;
        edge_step();
        edge_step();
        #2;
        chk("midrst_in_tval", {52'd0, bus.csr_wa}, 64'h343);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_excep = 1'b0;
        #1;
        chk("midrst_csr_wen", {63'd0, bus.csr_wen}, 64'd0);
        chk("midrst_csr_wa", {52'd0, bus.csr_wa}, 64'd0);
        chk("midrst_csr_wd", bus.csr_wd, 64'd0);
        chk("midrst_redir", {63'd0, bus.redirect_valid}, 64'd0);
        chk("midrst_priv", {62'd0, bus.priv}, 64'd3);
        chk("midrst_instret", bus.instret, 64'd0);
        m_priv    = 2'd3;
        m_instret = 64'd0;
        edge_step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) idle_cycle();

        // Randomized stream
        for (int n = 0; n < 200; n++) begin
            int unsigned kind;
            logic [63:0] cause;
            logic [63:0] mtvec;
            kind  = $urandom_range(0, 9);
            cause = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) cause = {1'b1, 57'd0, 6'($urandom_range(0, 63))};
            mtvec = {$urandom, $urandom};
            mtvec[1:0] = 2'($urandom_range(0, 1));
            run_instr($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), {$urandom, $urandom},
                      $urandom_range(0, 1) == 1, 12'($urandom), {$urandom, $urandom},
                      kind < 2, cause, {$urandom, $urandom},
                      kind >= 2 && kind < 4 ? 1'b1 : (kind == 0 ? 1'b1 : 1'b0),
                      {$urandom, $urandom}, {$urandom, $urandom}, mtvec, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_commit.md
# trap_commit

Writeback/commit stage driving the write side of the decode-stage register file and CSR file. Retires one instruction per cycle from the memory stage: GPR writes, CSR writes, a retired-instruction count. Sequences multi-cycle trap entry through the single CSR write port, then redirects fetch and flushes the pipeline. Also executes `mret` and owns the current privilege mode.

## Interface
Parameters:
- `XLEN`, default 64: data width.
- `MTVEC_VEC_EN`, default 1: honour vectored `mtvec` mode for interrupts.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: memory-stage instruction valid.
- `in_ready` out 1: commit can accept this cycle; 1 only in IDLE.
- `in_pc` in XLEN: instruction PC.
- `in_regwrite` in 1: instruction writes a GPR.
- `in_dst` in 5: destination register.
- `in_result` in XLEN: GPR write data.
- `in_csrwrite` in 1: instruction writes a CSR.
- `in_csraddr` in 12: CSR address.
- `in_csrdata` in XLEN: CSR write data.
- `in_excep` in 1: instruction raised an exception or took an interrupt.
- `in_cause` in XLEN: mcause value; bit 63 marks an interrupt.
- `in_tval` in XLEN: mtval value.
- `in_mret` in 1: instruction is `mret`.
- `mstatus_q` in XLEN: current mstatus, from the CSR file.
- `mtvec_q` in XLEN: current mtvec, from the CSR file.
- `mepc_q` in XLEN: current mepc, from the CSR file.
- `wen` out 1: GPR write enable.
- `wa` out 5: GPR write address.
- `wd` out XLEN: GPR write data.
- `csr_wen` out 1: CSR write enable.
- `csr_wa` out 12: CSR write address.
- `csr_wd` out XLEN: CSR write data.
- `redirect_valid` out 1: one-cycle fetch redirect and pipeline flush.
- `redirect_pc` out XLEN: redirect target.
- `priv` out 2: current privilege mode.
- `instret` out 64: retired-instruction counter.

## Operation
- States: IDLE, T_CAUSE, T_TVAL, T_STATUS.
- Accept: `in_valid & in_ready` in IDLE.
- Priority on an accepted instruction: `in_excep` > `in_mret` > normal.

Normal instruction (IDLE):
- `wen = in_regwrite & (in_dst != 0)`, `wa = in_dst`, `wd = in_result`.
- `csr_wen = in_csrwrite`, `csr_wa`/`csr_wd` taken from the inputs.
- GPR and CSR writes in the same cycle are allowed.
- `instret` increments at the clock edge.

Exception (accepted in IDLE):
- GPR and instruction CSR writes are suppressed.
- CSR write of mepc (0x341) = `in_pc`.
- Latched at the edge: cause, tval, mstatus snapshot, `priv`.
- State goes to T_CAUSE.
- T_CAUSE: write mcause (0x342) with the latched cause; go to T_TVAL.
- T_TVAL: write mtval (0x343); go to T_STATUS.
- T_STATUS:
  - write mstatus (0x300) with MPIE[7] = MIE[3], MIE = 0, MPP[12:11] = latched priv;
  - `redirect_valid = 1`;
  - `redirect_pc` = `{mtvec_q[63:2],2'b00}`, or that base + 4·cause[5:0] when `mtvec_q[1:0]==1`, `MTVEC_VEC_EN` is set and cause bit 63 is set;
  - `priv` becomes 3 at the edge; go to IDLE.
- `instret` does not increment on an exception.

`mret` (accepted in IDLE, single cycle):
- Write mstatus with MIE = MPIE, MPIE = 1, MPP = 0.
- `redirect_valid = 1`, `redirect_pc = mepc_q`.
- At the edge, `priv` takes the old MPP; `instret` increments.

Other rules:
- When `in_valid = 0` or the instruction is not accepted, all write enables are 0.
- Unused outputs are 0.

## Timing
- Reset values: state IDLE, `priv = 3`, `instret = 0`. All enables and `redirect_valid` are 0; addresses and data are 0.
- Normal and `mret` commits: zero-latency combinational outputs in the acceptance cycle; the write takes effect at that clock edge.
- Trap: 4 cycles total (mepc, mcause, mtval, mstatus+redirect). `in_ready = 0` for the last 3.
- `redirect_valid` is high for exactly one cycle.
- Inputs arriving while not ready must be held by upstream. They are flushed by the redirect and never committed.
- The mstatus value is taken from the snapshot latched at trap acceptance; `mstatus_q` is not re-read later.
- `reset` asserted mid-trap returns to IDLE immediately and abandons the remaining CSR writes.
- `in_excep` and `in_mret` both set: trap path only.
- `instret` wraps from 2^64-1 to 0.

## Structure
- `pipes` package gets:
  - `commit_data_t`, bundling the `in_*` fields;
  - `trap_state_t`, the enum of the four states.
- `common` package gets:
  - CSR address constants `CSR_MSTATUS`, `CSR_MTVEC`, `CSR_MEPC`, `CSR_MCAUSE`, `CSR_MTVAL`;
  - privilege constants `PRIV_U = 0` and `PRIV_M = 3`.
- One combinational sub-module, `mstatus_xfer`, computes the trap-entry and mret mstatus values and the `mret` target privilege.

## Test plan
1. **Normal writes.** ADDI with x5 = 0x10, then a write to x0.
   - Expect `wen = 1`, `wa = 5`, `wd = 0x10`, then `wen = 0`.
   - `instret` counts 2.
2. **Exception.** Exception at pc 0x8000_0010, cause 2, tval 0xdead, mstatus 0x8, `mtvec_q` 0x8000_0100, priv 3.
   - CSR writes appear on consecutive cycles: 0x341 = 0x8000_0010, 0x342 = 2, 0x343 = 0xdead, 0x300 = 0x1880.
   - `redirect_pc` = 0x8000_0100.
   - `in_ready = 0` for 3 cycles; `instret` unchanged.
3. **Vectored interrupt.** Cause 0x8000_0000_0000_0007 with `mtvec_q` 0x8000_0101.
   - Expect `redirect_pc` = 0x8000_011C.
4. **mret.** mstatus 0x80 (MPIE = 1, MPP = 0), `mepc_q` 0x8000_0200.
   - Same cycle: csr 0x300 = 0x88, redirect to 0x8000_0200.
   - Next cycle: `priv = 0`.
5. **Simultaneous flags.** Exception with `in_regwrite` and `in_csrwrite` set.
   - `wen = 0`, and the instruction's CSR address is never written.
   - An instruction with both `in_excep` and `in_mret` set follows the trap path.
6. **Reset mid-trap.** Assert `reset` in T_TVAL.
   - Outputs go to 0 immediately, `priv = 3`, `in_ready = 1` after release, and no mstatus write occurs.
